abr_masked_n_bit_sub: RTL and testbench
=======================================

Name: abr_masked_n_bit_sub

Overview:
Boolean-masked (2-share, domain-oriented) ripple subtractor: computes D = X - Y mod 2^WIDTH plus a masked borrow, on share-split operands.
- One masked bit-slice per pipeline stage; each slice is the full-adder datapath with Y inverted and carry-in forced to 1.
- Fully pipelined: accepts one operation per cycle, no backpressure.
- Sits next to the masked adder in the boolean-domain arithmetic path of the sampler/decompose logic.

Parameters:
WIDTH, 8, operand/result bit width (>=2); also the pipeline depth.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
zeroize  input  1  synchronous clear of all state
valid_i  input  1  operands valid this cycle
x0_i  input  WIDTH  share 0 of X
x1_i  input  WIDTH  share 1 of X (X = x0_i ^ x1_i)
y0_i  input  WIDTH  share 0 of Y
y1_i  input  WIDTH  share 1 of Y
rnd_i  input  WIDTH  fresh random bits, one per stage, every cycle
valid_o  output  1  result valid
d0_o  output  WIDTH  share 0 of D
d1_o  output  WIDTH  share 1 of D
borrow_o  output  2  shares of borrow (1 when X < Y unsigned)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Every flop, including valid_o, d0_o, d1_o and borrow_o, resets to 0.
- Zeroize: synchronous. It clears every flop (skew buffers, masked-AND internals, valid pipe) and has priority over valid_i in the same cycle, so an operation issued that cycle is dropped.
- Y inversion: apply to share 0 only (~y0, y1). Initial carry shares are (1,0).
- Stage k (0..WIDTH-1), per share i:
  - a_i = x_i ^ yn_i
  - b_i = x_i ^ c_i
  - s_i = a_i ^ c_i
  - carry_out_i = x_i ^ AND_i(a,b)
- The masked AND is DOM: one register stage, consumes rnd_i[k] in the cycle stage k evaluates.
- Never combine the two shares of any value in logic, and do not reuse a random bit across stages.
- Timing for an operation with valid_i=1 in cycle t:
  - Stage k evaluates in cycle t+k.
  - Input bit k of X and Y is delayed k cycles by a per-bit share-preserving skew buffer.
  - c_{k+1} is available in cycle t+k+1.
  - Sum bit k is registered at the end of t+k and deskewed by WIDTH-1-k cycles.
- Output: in cycle t+WIDTH, valid_o=1 and d0_o, d1_o, borrow_o all hold that operation's result.
  - Latency is exactly WIDTH cycles.
  - Outputs are registered.
  - Outputs hold their last value while valid_o=0.
- borrow_o = (~c_WIDTH share0, c_WIDTH share1).
- Throughput: valid_i may be high every cycle; results emerge in issue order, one per cycle.
- Bubbles propagate as valid_o=0.
- rnd_i is sampled every cycle regardless of valid_i.
- Boundaries:
  - X=Y gives D=0, borrow 0.
  - X=0, Y=2^WIDTH-1 gives D=1, borrow 1.
  - Wrap-around is mod 2^WIDTH.
  - Reset or zeroize mid-flight loses all in-flight operations; no spurious valid_o afterwards.

Optional Feature:
ABR_MASKED_SUB_ADD_MODE_EN:
- Defined: adds port sub_i (input, 1), pipelined alongside valid_i.
  - sub_i=1 gives subtraction as above.
  - sub_i=0 skips the Y inversion and uses carry-in shares (0,0), giving D = X+Y mod 2^WIDTH.
  - In add mode borrow_o carries the masked carry-out un-inverted.
  - The mode is per operation, so mixed back-to-back ops are allowed.
- Undefined: no sub_i port; always subtract.

Test Plan:
1. WIDTH=8, X=0x05, Y=0x03, random share splits and rnd_i -> 8 cycles later valid_o=1, d0^d1=0x02, borrow shares XOR to 0.
2. X=0x03, Y=0x05 -> D=0xFE, borrow XOR = 1; also X=0x00, Y=0xFF -> D=0x01, borrow 1; X=Y=0xA7 -> D=0x00, borrow 0.
3. Back-to-back ops (9-4, 200-201, 0-0) in cycles t..t+2 -> valid_o high t+8..t+10 with D=0x05/0xFF/0x00 and borrows 0/1/0; a single bubble inserted -> a matching valid_o gap.
4. Zeroize at cycle t+3 with 4 ops in flight -> all state cleared next edge, no valid_o for those ops, outputs read 0; an op issued with zeroize high is dropped.
5. Randomized 10k ops with random shares and rnd_i, including rnd_i stuck at 0 -> unmasked result always equals the reference X-Y mod 256; assert no share-0/share-1 cross terms in the netlist (structural check).
6. With ABR_MASKED_SUB_ADD_MODE_EN: sub_i=0, X=0xF0, Y=0x20 -> D=0x10, carry XOR 1; next cycle sub_i=1 same operands -> D=0xD0, borrow 0.

Source files
------------

// File: rtl/abr_masked_n_bit_sub.sv
// Two-share Boolean-masked ripple subtractor, one DOM bit-slice per pipeline stage.
// Optional ABR_MASKED_SUB_ADD_MODE_EN adds a per-operation sub_i select (1 = X-Y, 0 = X+Y).
module abr_masked_n_bit_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zeroize,
  input  logic             valid_i,
`ifdef ABR_MASKED_SUB_ADD_MODE_EN
  input  logic             sub_i,
`endif
  input  logic [WIDTH-1:0] x0_i,
  input  logic [WIDTH-1:0] x1_i,
  input  logic [WIDTH-1:0] y0_i,
  input  logic [WIDTH-1:0] y1_i,
  input  logic [WIDTH-1:0] rnd_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] d0_o,
  output logic [WIDTH-1:0] d1_o,
  output logic [1:0]       borrow_o
);

  logic [WIDTH:1]   r_vld;
  logic             w_sub_in;
  logic             w_sub_last;
  logic             w_last_en;
  logic [WIDTH:0]   w_c0;
  logic [WIDTH:0]   w_c1;
  logic [WIDTH-1:0] w_y0n;

  // Stage valid pipe: r_vld[k] marks an operation sitting in stage k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (zeroize) begin
      r_vld <= '0;
    end else begin
      r_vld[1] <= valid_i;
      for (int j = 2; j <= WIDTH; j++) r_vld[j] <= r_vld[j-1];
    end
  end

`ifdef ABR_MASKED_SUB_ADD_MODE_EN
  logic [WIDTH-1:1] r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= '0;
    end else if (zeroize) begin
      r_mode <= '0;
    end else begin
      r_mode[1] <= sub_i;
      for (int j = 2; j < WIDTH; j++) r_mode[j] <= r_mode[j-1];
    end
  end

  assign w_sub_in   = sub_i;
  assign w_sub_last = r_mode[WIDTH-1];
`else
  assign w_sub_in   = 1'b1;
  assign w_sub_last = 1'b1;
`endif

  assign valid_o   = r_vld[WIDTH];
  assign w_last_en = r_vld[WIDTH-1];

  // Subtraction inverts only share 0 of Y and seeds the carry shares with (1,0).
  assign w_y0n   = y0_i ^ {WIDTH{w_sub_in}};
  assign w_c0[0] = w_sub_in;
  assign w_c1[0] = 1'b0;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    localparam bit LAST = (k == WIDTH - 1);

    logic [3:0] w_in;
    logic [3:0] w_op;
    logic       w_x0, w_x1, w_yn0, w_yn1;
    logic       w_a0, w_a1, w_b0, w_b1, w_s0, w_s1;
    logic       w_en, w_inv;
    logic       r_in0, r_in1, r_cr0, r_cr1;
    logic [1:0] w_snext;
    logic [1:0] r_so;

    assign w_in = {y1_i[k], w_y0n[k], x1_i[k], x0_i[k]};

    // Input skew: bit k waits k cycles so it meets its carry.
    if (k == 0) begin : g_noskew
      assign w_op = w_in;
    end else begin : g_skew
      logic [3:0] r_sk [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) r_sk[j] <= '0;
        end else if (zeroize) begin
          for (int j = 0; j < k; j++) r_sk[j] <= '0;
        end else begin
          r_sk[0] <= w_in;
          for (int j = 1; j < k; j++) r_sk[j] <= r_sk[j-1];
        end
      end

      assign w_op = r_sk[k-1];
    end

    assign w_x0  = w_op[0];
    assign w_x1  = w_op[1];
    assign w_yn0 = w_op[2];
    assign w_yn1 = w_op[3];

    assign w_a0 = w_x0 ^ w_yn0;
    assign w_a1 = w_x1 ^ w_yn1;
    assign w_b0 = w_x0 ^ w_c0[k];
    assign w_b1 = w_x1 ^ w_c1[k];
    assign w_s0 = w_a0 ^ w_c0[k];
    assign w_s1 = w_a1 ^ w_c1[k];

    // The final slice holds its result between operations and folds the borrow inversion into share 0.
    assign w_en  = !LAST || w_last_en;
    assign w_inv = LAST && w_sub_last;

    // DOM AND: in-domain terms with x folded in, cross-domain terms refreshed by rnd_i[k].
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_in0 <= 1'b0;
        r_in1 <= 1'b0;
        r_cr0 <= 1'b0;
        r_cr1 <= 1'b0;
      end else if (zeroize) begin
        r_in0 <= 1'b0;
        r_in1 <= 1'b0;
        r_cr0 <= 1'b0;
        r_cr1 <= 1'b0;
      end else if (w_en) begin
        r_in0 <= w_x0 ^ (w_a0 & w_b0) ^ w_inv;
        r_in1 <= w_x1 ^ (w_a1 & w_b1);
        r_cr0 <= (w_a0 & w_b1) ^ rnd_i[k];
        r_cr1 <= (w_a1 & w_b0) ^ rnd_i[k];
      end
    end

    assign w_c0[k+1] = r_in0 ^ r_cr0;
    assign w_c1[k+1] = r_in1 ^ r_cr1;

    // Sum deskew: WIDTH-1-k free-running stages, then the held output register.
    if (LAST) begin : g_nodeskew
      assign w_snext = {w_s1, w_s0};
    end else begin : g_deskew
      logic [1:0] r_sd [WIDTH-1-k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < WIDTH - 1 - k; j++) r_sd[j] <= '0;
        end else if (zeroize) begin
          for (int j = 0; j < WIDTH - 1 - k; j++) r_sd[j] <= '0;
        end else begin
          r_sd[0] <= {w_s1, w_s0};
          for (int j = 1; j < WIDTH - 1 - k; j++) r_sd[j] <= r_sd[j-1];
        end
      end

      assign w_snext = r_sd[WIDTH-2-k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_so <= '0;
      end else if (zeroize) begin
        r_so <= '0;
      end else if (w_last_en) begin
        r_so <= w_snext;
      end
    end

    assign d0_o[k] = r_so[0];
    assign d1_o[k] = r_so[1];
  end

  assign borrow_o = {w_c1[WIDTH], w_c0[WIDTH]};

endmodule

// File: tb/tb_abr_masked_n_bit_sub.sv
// Scoreboard bench for abr_masked_n_bit_sub: directed vectors with hand-computed results,
// checked in issue order against valid_o timing by an independent monitor.
module tb_abr_masked_n_bit_sub;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         zeroize;
  logic         valid_i;
  logic [W-1:0] x0, x1, y0, y1, rnd;
  logic         valid_o;
  logic [W-1:0] d0_o, d1_o;
  logic [1:0]   borrow_o;
`ifdef ABR_MASKED_SUB_ADD_MODE_EN
  logic         sub_i;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_zero = 0;

  abr_masked_n_bit_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .zeroize  (zeroize),
    .valid_i  (valid_i),
`ifdef ABR_MASKED_SUB_ADD_MODE_EN
    .sub_i    (sub_i),
`endif
    .x0_i     (x0),
    .x1_i     (x1),
    .y0_i     (y0),
    .y1_i     (y1),
    .rnd_i    (rnd),
    .valid_o  (valid_o),
    .d0_o     (d0_o),
    .d1_o     (d1_o),
    .borrow_o (borrow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per presented result.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("diff", d0_o ^ d1_o, e.d);
        chk("borrow", borrow_o[0] ^ borrow_o[1], e.b);
      end
    end
  end

  // One clock of stimulus; an op issued alongside zeroize is never expected.
  task automatic issue(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] d, input logic b, input bit z);
    logic [W-1:0] m;
    m   = W'($urandom);
    x0  = m;
    x1  = m ^ x;
    m   = W'($urandom);
    y0  = m;
    y1  = m ^ y;
    rnd = rnd_zero ? '0 : W'($urandom);
    valid_i = v;
    zeroize = z;
    if (v && !z) q.push_back('{d: d, b: b, cyc: cyc + W});
    @(posedge clk);
    if (z) q.delete();
    #1;
    valid_i = 1'b0;
    zeroize = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    zeroize = 1'b0;
    valid_i = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; rnd = '0;
`ifdef ABR_MASKED_SUB_ADD_MODE_EN
    sub_i = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_d0", {24'd0, d0_o}, 32'd0);
    chk("reset_d1", {24'd0, d1_o}, 32'd0);
    chk("reset_borrow", {30'd0, borrow_o}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Isolated operations, including both wrap directions and X=Y.
    issue(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0); idle(W + 1);
    issue(1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0); idle(W + 1);
    issue(1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0); idle(W + 1);
    issue(1'b1, 8'hA7, 8'hA7, 8'h00, 1'b0, 1'b0); idle(W + 1);

    // Back-to-back, then a single bubble, then a burst.
    issue(1'b1, 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);
    issue(1'b1, 8'hC8, 8'hC9, 8'hFF, 1'b1, 1'b0);
    issue(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(1);
    issue(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);
    issue(1'b1, 8'h01, 8'h80, 8'h81, 1'b1, 1'b0);
    issue(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    issue(1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    issue(1'b1, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0);
    issue(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0);
    issue(1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    idle(W + 2);

    // Same arithmetic with the refresh randomness stuck at zero.
    rnd_zero = 1'b1;
    issue(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    issue(1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    issue(1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    issue(1'b1, 8'h6B, 8'h2E, 8'h3D, 1'b0, 1'b0);
    idle(W + 2);
    rnd_zero = 1'b0;

    // Zeroize with three ops in flight plus one issued in the zeroize cycle.
    issue(1'b1, 8'h11, 8'h22, 8'hEF, 1'b1, 1'b0);
    issue(1'b1, 8'h22, 8'h11, 8'h11, 1'b0, 1'b0);
    issue(1'b1, 8'h44, 8'h44, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 8'h55, 8'h01, 8'h54, 1'b0, 1'b1);
    chk("zeroize_valid", {31'd0, valid_o}, 32'd0);
    chk("zeroize_d0", {24'd0, d0_o}, 32'd0);
    chk("zeroize_d1", {24'd0, d1_o}, 32'd0);
    chk("zeroize_borrow", {30'd0, borrow_o}, 32'd0);
    idle(W + 2);
    issue(1'b1, 8'h20, 8'h01, 8'h1F, 1'b0, 1'b0);
    idle(W + 2);

    // Asynchronous reset mid-flight drops everything in the pipe.
    issue(1'b1, 8'h30, 8'h10, 8'h20, 1'b0, 1'b0);
    issue(1'b1, 8'h31, 8'h10, 8'h21, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    q.delete();
    #2;
    chk("midreset_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(W + 2);

`ifdef ABR_MASKED_SUB_ADD_MODE_EN
    sub_i = 1'b0;
    issue(1'b1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
    sub_i = 1'b1;
    issue(1'b1, 8'hF0, 8'h20, 8'hD0, 1'b0, 1'b0);
    sub_i = 1'b0;
    issue(1'b1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    sub_i = 1'b1;
    idle(W + 2);
`endif

    chk("pending_results", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
